// File: rtl/uart_receiver.sv
`default_nettype none
// ============================================================================
// Module      : uart_receiver
// Description : Serial-to-parallel UART receiver for 8N1 frames (1 start bit,
//               8 data bits, 1 stop bit). The line passes through a
//               reset-to-idle synchroniser. Each data bit is sampled at clock
//               (CLKS_PER_BIT-1)/2 of its bit period. The received byte is
//               held in an output register with a valid/ack handshake.
//               Framing errors and overruns are reported as one-clock pulses.
//
// Parameters  : CLKS_PER_BIT - clocks per serial bit (>= 1)
//               SYNC_STAGES  - synchroniser depth on uart_rx (>= 1)
//
// Ports       : clk        in   rising-edge clock
//               rst        in   synchronous active-high reset
//               uart_rx    in   serial line, idle high
//               data       out  [0:7] received byte, index 0 = first bit on line
//               data_valid out  data holds an unconsumed byte
//               data_ack   in   consumer takes data (honoured while data_valid)
//               frame_err  out  1-clock pulse: stop bit sampled as 0
//               overrun    out  1-clock pulse: good frame overwrote unread byte
//               busy       out  FSM is not idle
//
// Revision    : 1.0 - initial release
// ============================================================================
module uart_receiver #(
    parameter int CLKS_PER_BIT = 1,
    parameter int SYNC_STAGES  = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       uart_rx,
    output logic [0:7] data,
    output logic       data_valid,
    input  logic       data_ack,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    // Mid-bit sample point, counted in clocks from the start of a bit.
    localparam int c_HALF  = (CLKS_PER_BIT - 1) / 2;
    localparam int c_CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    localparam logic [c_CNT_W-1:0] c_CNT_LAST    = c_CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_HALF_M1 = c_CNT_W'((c_HALF > 0) ? (c_HALF - 1) : 0);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE     = c_CNT_W'(1);

    // With oversampling the stop-sample point lies mid-bit, so a low stop bit
    // still has half a bit of low line left; a new start must then be a fresh
    // falling edge rather than that remainder.
    localparam bit c_EDGE_START = (CLKS_PER_BIT > 1);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_START = 2'd1;
    localparam logic [1:0] c_DATA  = 2'd2;
    localparam logic [1:0] c_STOP  = 2'd3;

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_rx_s;

    logic [1:0]         r_state;
    logic [1:0]         w_state_next;
    logic [c_CNT_W-1:0] r_clk_cnt;
    logic [2:0]         r_bit_cnt;
    logic [0:7]         r_shift;
    logic               r_need_high;

    logic w_cnt_last;
    logic w_start_chk;
    logic w_start_det;
    logic w_sample;
    logic w_good;
    logic w_bad;

    // ------------------------------------------------------------------
    // Line synchroniser; resets to the idle (high) level so that reset
    // never fabricates a start bit.
    // ------------------------------------------------------------------
    generate
        if (SYNC_STAGES == 1) begin : g_sync_single
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_sync <= '1;
                end else begin
                    r_sync <= uart_rx;
                end
            end
        end else begin : g_sync_chain
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_sync <= '1;
                end else begin
                    r_sync <= {r_sync[SYNC_STAGES-2:0], uart_rx};
                end
            end
        end
    endgenerate

    assign w_rx_s      = r_sync[SYNC_STAGES-1];
    assign w_cnt_last  = (r_clk_cnt == c_CNT_LAST);
    assign w_start_chk = (r_clk_cnt == c_CNT_HALF_M1);
    assign w_start_det = ~w_rx_s & ~r_need_high;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state. When the mid-bit point is clock 0 of the bit, the
    // detecting edge already is the start-bit sample, so START is skipped.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_IDLE: begin
                if (w_start_det) begin
                    w_state_next = (c_HALF == 0) ? c_DATA : c_START;
                end
            end
            c_START: begin
                if (w_start_chk) begin
                    w_state_next = w_rx_s ? c_IDLE : c_DATA;
                end
            end
            c_DATA: begin
                if (w_cnt_last && (r_bit_cnt == 3'd7)) begin
                    w_state_next = c_STOP;
                end
            end
            c_STOP: begin
                if (w_cnt_last) begin
                    w_state_next = c_IDLE;
                end
            end
            default: w_state_next = c_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs and sample strobes
    // ------------------------------------------------------------------
    always_comb begin
        busy     = (r_state != c_IDLE);
        w_sample = 1'b0;
        w_good   = 1'b0;
        w_bad    = 1'b0;
        case (r_state)
            c_DATA: w_sample = w_cnt_last;
            c_STOP: begin
                w_good = w_cnt_last & w_rx_s;
                w_bad  = w_cnt_last & ~w_rx_s;
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Bit timing and deserialisation. Leaving START clears the clock
    // counter at mid-bit, so every later sample also lands mid-bit one
    // full period later.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_clk_cnt   <= '0;
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            r_need_high <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    r_clk_cnt <= '0;
                    r_bit_cnt <= '0;
                end
                c_START: r_clk_cnt <= w_start_chk ? '0 : (r_clk_cnt + c_CNT_ONE);
                default: r_clk_cnt <= w_cnt_last ? '0 : (r_clk_cnt + c_CNT_ONE);
            endcase

            if (w_sample) begin
                r_shift[r_bit_cnt] <= w_rx_s;
                r_bit_cnt          <= r_bit_cnt + 3'd1;
            end

            if (w_rx_s) begin
                r_need_high <= 1'b0;
            end else if (w_bad && c_EDGE_START) begin
                r_need_high <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Output register and handshake. A good frame always wins over an ack
    // on the same edge, so the new byte is never lost.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            data       <= '0;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            frame_err <= w_bad;
            overrun   <= w_good & data_valid & ~data_ack;
            if (w_good) begin
                data       <= r_shift;
                data_valid <= 1'b1;
            end else if (data_ack) begin
                data_valid <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_receiver.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_receiver
// Description : Scoreboard bench for uart_receiver. Two instances run side by
//               side: one at one clock per bit and one at 16 clocks per bit.
//               The stimulus side serialises bytes onto the line and queues
//               the expected completion. The monitor side detects each byte
//               or error the DUT presents, pops the queue and compares. It
//               also drives the consumer ack and tracks whether an unread
//               byte should be pending.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_receiver;

    localparam int SYNC = 2;
    localparam int CPB0 = 1;
    localparam int CPB1 = 16;

    typedef struct {
        bit         bad;
        logic [7:0] value;
        int         t_exp;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] rx;
    logic [1:0] ack = '0;
    logic [0:7] dout [2];
    logic [1:0] dv;
    logic [1:0] ferr;
    logic [1:0] ovr;
    logic [1:0] busy;

    int   cyc    = 0;
    int   errors = 0;
    int   checks = 0;
    exp_t exp_q [2][$];
    int   ack_mode [2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_receiver #(.CLKS_PER_BIT(CPB0), .SYNC_STAGES(SYNC)) u_dut0 (
        .clk(clk), .rst(rst), .uart_rx(rx[0]), .data(dout[0]), .data_valid(dv[0]),
        .data_ack(ack[0]), .frame_err(ferr[0]), .overrun(ovr[0]), .busy(busy[0])
    );

    uart_receiver #(.CLKS_PER_BIT(CPB1), .SYNC_STAGES(SYNC)) u_dut1 (
        .clk(clk), .rst(rst), .uart_rx(rx[1]), .data(dout[1]), .data_valid(dv[1]),
        .data_ack(ack[1]), .frame_err(ferr[1]), .overrun(ovr[1]), .busy(busy[1])
    );

    task automatic check(input string name, input int inst,
                         input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s dut%0d cycle %0d: got 0x%0h, expected 0x%0h",
                     name, inst, cyc, act, req);
        end
    endtask

    task automatic fail_now(input string name, input int inst, input string detail);
        checks++;
        errors++;
        $display("FAIL %s dut%0d cycle %0d: %s", name, inst, cyc, detail);
    endtask

    function automatic int cpb(input int i);
        return (i == 0) ? CPB0 : CPB1;
    endfunction

    // Line stop-bit start to output update, in clocks.
    function automatic int lat(input int i);
        return SYNC + (cpb(i) - 1) / 2 + 1;
    endfunction

    // ------------------------------------------------------------------
    // Monitor: runs on the falling edge, so everything it reads is the
    // state after the rising edge numbered cyc.
    // ------------------------------------------------------------------
    bit         srst = 1'b1;     // rst as seen by the last rising edge
    bit   [1:0] spv  = '0;       // data_valid before the last rising edge
    bit   [1:0] spa  = '0;       // data_ack seen by the last rising edge
    bit         pend [2];
    logic [7:0] last [2];
    exp_t       e;
    bit         ev_good;
    bit         ev_bad;
    bit         a;

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (srst) begin
                check("reset_outputs", i, {dout[i], dv[i], ferr[i], ovr[i], busy[i]}, 32'd0);
                pend[i] = 1'b0;
                last[i] = 8'h00;
            end else begin
                if (exp_q[i].size() > 0) begin
                    e = exp_q[i][0];
                    if (e.t_exp < cyc) begin
                        void'(exp_q[i].pop_front());
                        fail_now("missing_output", i,
                                 $sformatf("byte 0x%0h due at cycle %0d never presented", e.value, e.t_exp));
                    end
                end
                // A new byte shows as valid rising, valid held over an ack,
                // or an overrun pulse.
                ev_good = dv[i] && (!spv[i] || spa[i] || ovr[i]);
                ev_bad  = ferr[i];
                if (ev_good || ev_bad) begin
                    if (exp_q[i].size() == 0) begin
                        fail_now("unexpected_output", i,
                                 $sformatf("valid=%0b frame_err=%0b overrun=%0b with nothing sent",
                                           dv[i], ferr[i], ovr[i]));
                    end else begin
                        e = exp_q[i].pop_front();
                        check("latency", i, cyc, e.t_exp);
                        check("frame_err", i, ferr[i], e.bad);
                        if (!e.bad) begin
                            check("data", i, dout[i], e.value);
                            check("overrun", i, ovr[i], pend[i] && !spa[i]);
                            pend[i] = 1'b1;
                            last[i] = e.value;
                        end else begin
                            check("overrun", i, ovr[i], 1'b0);
                            if (spa[i]) pend[i] = 1'b0;
                        end
                    end
                end else if (spa[i]) begin
                    pend[i] = 1'b0;
                end
                check("valid_level", i, dv[i], pend[i]);
                if (pend[i]) check("data_hold", i, dout[i], last[i]);
            end

            spv[i] = dv[i];
            case (ack_mode[i])
                0:       a = 1'b0;
                1:       a = dv[i];
                2: begin
                    a = 1'b0;
                    if (exp_q[i].size() > 0) begin
                        e = exp_q[i][0];
                        a = (e.t_exp == cyc + 1);
                    end
                end
                default: a = ($urandom_range(0, 3) == 0);
            endcase
            ack[i] = a;
            spa[i] = a;
        end
        srst = rst;
    end

    // ------------------------------------------------------------------
    // Stimulus: each line bit is applied just after a rising edge; cyc then
    // names the edge that launched it.
    // ------------------------------------------------------------------
    task automatic drive_bit(input int i, input bit b);
        rx[i] = b;
        repeat (cpb(i)) @(posedge clk);
        #1;
    endtask

    task automatic idle(input int i, input int n);
        rx[i] = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input int i, input logic [7:0] v, input bit stop_ok);
        exp_t x;
        drive_bit(i, 1'b0);
        for (int k = 0; k < 8; k++) begin
            // The first data bit on the line is the byte's MSB (data index 0).
            if (k == 4) begin
                rx[i] = v[7-k];
                @(negedge clk);
                check("busy_mid_frame", i, busy[i], 1'b1);
                repeat (cpb(i)) @(posedge clk);
                #1;
            end else begin
                drive_bit(i, v[7-k]);
            end
        end
        x.bad   = !stop_ok;
        x.value = v;
        x.t_exp = cyc + lat(i);
        exp_q[i].push_back(x);
        drive_bit(i, stop_ok);
    endtask

    initial begin
        logic [7:0] v;
        bit         ok;
        int         gap;

        rst = 1'b1;
        rx  = '1;
        ack_mode[0] = 1;
        ack_mode[1] = 1;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b0;

        // Single byte: line 1,1,0,1,0,1,0,0,1,0,1,1 gives 0xA5.
        idle(0, 2);
        send_frame(0, 8'hA5, 1'b1);
        idle(0, 2);

        // Back-to-back frames, consumer acking every valid cycle.
        send_frame(0, 8'h3C, 1'b1);
        send_frame(0, 8'hC3, 1'b1);
        idle(0, 6);

        // Framing error, then a good frame straight after it.
        send_frame(0, 8'hFF, 1'b0);
        send_frame(0, 8'h01, 1'b1);
        idle(0, 6);

        // Overrun with no consumer, then drain.
        ack_mode[0] = 0;
        send_frame(0, 8'h11, 1'b1);
        send_frame(0, 8'h22, 1'b1);
        idle(0, 5);
        ack_mode[0] = 1;
        idle(0, 5);

        // Ack exactly on the completion edge: no overrun.
        ack_mode[0] = 2;
        send_frame(0, 8'h11, 1'b1);
        send_frame(0, 8'h22, 1'b1);
        idle(0, 5);
        ack_mode[0] = 1;
        idle(0, 5);

        // Glitch rejection at 16 clocks per bit, then a real frame.
        idle(1, 20);
        rx[1] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        idle(1, 40);
        check("glitch_idle", 1, busy[1], 1'b0);
        send_frame(1, 8'h5A, 1'b1);
        idle(1, 40);

        // Reset during data bit 4 with an unread byte pending.
        ack_mode[0] = 0;
        send_frame(0, 8'h33, 1'b1);
        drive_bit(0, 1'b0);
        for (int k = 0; k < 4; k++) drive_bit(0, k[0]);
        rx[0] = 1'b1;
        rst   = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(0, 10);
        ack_mode[0] = 1;
        send_frame(0, 8'h81, 1'b1);
        idle(0, 6);

        // Randomised traffic at one clock per bit with random acks.
        ack_mode[0] = 3;
        for (int n = 0; n < 60; n++) begin
            v   = 8'($urandom_range(0, 255));
            ok  = ($urandom_range(0, 6) != 0);
            send_frame(0, v, ok);
            gap = $urandom_range(0, 2);
            if (gap > 0) idle(0, gap);
        end
        idle(0, 8);
        ack_mode[0] = 1;

        // Randomised traffic at 16 clocks per bit.
        ack_mode[1] = 3;
        for (int n = 0; n < 5; n++) begin
            v = 8'($urandom_range(0, 255));
            send_frame(1, v, 1'b1);
            gap = $urandom_range(0, 1);
            if (gap > 0) idle(1, gap * CPB1);
        end
        idle(1, 40);

        for (int w = 0; w < 500 && (exp_q[0].size() + exp_q[1].size()) > 0; w++) begin
            @(posedge clk);
        end
        if ((exp_q[0].size() + exp_q[1].size()) > 0) begin
            fail_now("drain_timeout", 0, $sformatf("%0d expected outputs never seen",
                     exp_q[0].size() + exp_q[1].size()));
        end
        repeat (4) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
